// File: rtl/toggle_handshake_rx.sv
// Consumer end of a two-phase (toggle) handshake link: synchronises req_tgl, captures
// the bundled word, presents it on valid/ready and toggles ack_tgl on each accept.
module toggle_handshake_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] req_data,
    output logic              ack_tgl,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    input  logic              rx_ready,
    output logic [CNT_W-1:0]  evt_count,
    output logic              overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_in;
    logic                   prev_reg;
    logic                   edge_det;

    logic              ack_reg, ack_next;
    logic              rx_valid_reg, rx_valid_next;
    logic [DATA_W-1:0] rx_data_reg, rx_data_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              overrun_reg, overrun_next;
    logic              accept;

    // Each synchroniser stage takes the previous stage; stage 0 takes the raw toggle.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_in[gi] = req_tgl;
            end else begin : g_rest
                assign sync_in[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= sync_in;
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    // Either direction of the toggle is one request.
    assign edge_det = sync_reg[SYNC_STAGES-1] ^ prev_reg;
    assign accept   = rx_valid_reg & rx_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (edge_det) state_next = HOLD;
            HOLD:    if (accept)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        ack_next      = ack_reg;
        rx_valid_next = rx_valid_reg;
        rx_data_next  = rx_data_reg;
        cnt_next      = cnt_reg;
        overrun_next  = overrun_reg;
        case (state_reg)
            IDLE: begin
                if (edge_det) begin
                    rx_data_next  = req_data;
                    rx_valid_next = 1'b1;
                end
            end
            HOLD: begin
                // A toggle arriving before our ack is a sender violation; drop it.
                if (edge_det) begin
                    overrun_next = 1'b1;
                end
                if (accept) begin
                    rx_valid_next = 1'b0;
                    ack_next      = ~ack_reg;
                    cnt_next      = cnt_reg + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_reg      <= 1'b0;
            rx_valid_reg <= 1'b0;
            rx_data_reg  <= '0;
            cnt_reg      <= '0;
            overrun_reg  <= 1'b0;
        end else begin
            ack_reg      <= ack_next;
            rx_valid_reg <= rx_valid_next;
            rx_data_reg  <= rx_data_next;
            cnt_reg      <= cnt_next;
            overrun_reg  <= overrun_next;
        end
    end

    assign ack_tgl   = ack_reg;
    assign rx_valid  = rx_valid_reg;
    assign rx_data   = rx_data_reg;
    assign evt_count = cnt_reg;
    assign overrun   = overrun_reg;

endmodule
